uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 27000, maximum mid-packet stall in clock cycles (1 ms at 27 MHz).
REQ-003 SHALL have port clock  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  per-requester byte; requester i on bits [8*i+7:8*i].
REQ-007 SHALL have port req_last  input  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_data_valid  output  1  byte valid to the UART transmitter.
REQ-011 SHALL have port tx_data_ready  input  1  UART transmitter accept.
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot current owner; all zero when idle.
REQ-013 SHALL have port busy  output  1  high while a packet owns the transmitter.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on a forced grant release.

Function
REQ-015 SHALL implement two states: IDLE and XFER.
REQ-016 In IDLE, with any req_valid bit high at a rising edge, SHALL register a grant and enter XFER.
REQ-017 The grant SHALL go to the first requester with req_valid high, searching upward from last_gnt+1 modulo NUM_REQ.
REQ-018 In IDLE, SHALL hold grant=0, busy=0, tx_data_valid=0, req_ready=0 and tx_data=0.
REQ-019 In XFER, SHALL drive tx_data=req_data[gnt] and tx_data_valid=req_valid[gnt] combinationally, with zero added latency.
REQ-020 In XFER, SHALL drive req_ready[gnt]=tx_data_ready; all other req_ready bits SHALL be 0.
REQ-021 A byte SHALL transfer only in a cycle with req_valid[gnt], tx_data_ready and XFER all high.
REQ-022 On a transfer with req_last[gnt]=1, SHALL update last_gnt<=gnt, clear grant and return to IDLE.
REQ-023 Consecutive packets SHALL be separated by exactly one IDLE cycle.
REQ-024 The grant SHALL never change mid-packet, except on timeout.
REQ-025 Requests on other ports SHALL be ignored (no ready) until the current packet ends.
REQ-026 A 32-bit stall counter SHALL clear on every transfer and on entry to XFER.
REQ-027 The stall counter SHALL increment each XFER cycle with req_valid[gnt]=0.
REQ-028 Cycles where tx_data_ready=0 SHALL NOT count as stall.
REQ-029 When the stall counter reaches TIMEOUT_CYC, SHALL pulse timeout_err for one cycle, set last_gnt<=gnt, and return to IDLE.
REQ-030 No byte SHALL be transferred in the timeout cycle.
REQ-031 A requester holding req_valid continuously SHALL be granted within NUM_REQ packets, so no requester starves.
REQ-032 A single-byte packet (req_last high on the first byte) SHALL be legal.
REQ-033 busy SHALL equal (state==XFER), registered.

Reset
REQ-034 On rst_n low, SHALL asynchronously force state=IDLE, grant=0, busy=0, timeout_err=0, stall counter=0 and last_gnt=NUM_REQ-1, so requester 0 wins first.
REQ-035 Reset mid-packet SHALL abandon the packet with no further req_ready and no tx_data_valid until a new grant.
REQ-036 Outputs SHALL be glitch-free combinational functions of registered state and inputs; no output SHALL depend on rst_n except through the reset registers.

Verification
REQ-037 Bench SHALL cover: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_data_ready always 1 -> grant=0001 one cycle after valid, three consecutive transfers, then IDLE.
REQ-038 Bench SHALL cover: req0..req3 all valid, each with a 2-byte packet -> service order 0,1,2,3, with one IDLE cycle between packets.
REQ-039 Bench SHALL cover: req2 granted, tx_data_ready toggling 1-of-12 cycles (UART pacing) while req1 valid -> req1 never sees ready until req2's last byte, and no timeout_err.
REQ-040 Bench SHALL cover: TIMEOUT_CYC=16, req1 sends 1 byte without last and then drops valid -> timeout_err pulses exactly 17 cycles after the transfer, and the next grant goes to req2 if it is valid.
REQ-041 Bench SHALL cover: rst_n asserted mid-packet on req3 -> all outputs zero immediately, and after release req0 wins the first grant.
REQ-042 Bench SHALL cover: req1 holds a single-byte packet continuously for 8 packets while req0 is also requesting -> strict alternation 1,0,1,0 after the first grant.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART transmitter among byte-stream requesters
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 27000
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_gnt_q, last_gnt_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;

  logic [NUM_REQ-1:0] gnt_onehot;
  logic [7:0]         sel_data;
  logic               sel_valid;
  logic               sel_last;
  logic               pick_found;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand;
  logic               in_xfer;
  logic               fire;
  logic               stall;

  // Decode the owner index into a one-hot vector and select the owner's byte lane.
  always_comb begin
    gnt_onehot = '0;
    sel_data   = 8'h00;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q == IW'(i)) begin
        gnt_onehot[i] = 1'b1;
        sel_data      = req_data[8*i +: 8];
        sel_valid     = req_valid[i];
        sel_last      = req_last[i];
      end
    end
  end

  // Round-robin search: scan from farthest to nearest so the first valid requester after last_gnt wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((32'(last_gnt_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign in_xfer       = (state_q == XFER);
  assign grant         = in_xfer ? gnt_onehot : '0;
  assign tx_data       = in_xfer ? sel_data : 8'h00;
  assign tx_data_valid = in_xfer & sel_valid;
  assign req_ready     = (in_xfer & tx_data_ready) ? gnt_onehot : '0;
  assign fire          = in_xfer & sel_valid & tx_data_ready;
  // A stall is the owner going quiet while the transmitter could take a byte; UART back-pressure is not a stall.
  assign stall         = in_xfer & ~sel_valid & tx_data_ready;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

  // Next-state: grant on any request in IDLE, release on last byte or when the stall counter reaches the limit.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_gnt_d    = last_gnt_q;
    stall_cnt_d   = stall_cnt_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = XFER;
          gnt_d       = pick_idx;
          stall_cnt_d = '0;
        end
      end
      XFER: begin
        if (fire) begin
          stall_cnt_d = '0;
          if (sel_last) begin
            state_d    = IDLE;
            last_gnt_d = gnt_q;
            gnt_d      = '0;
          end
        end else if (stall) begin
          if (stall_cnt_q + 32'd1 >= TIMEOUT_CYC) begin
            state_d       = IDLE;
            last_gnt_d    = gnt_q;
            gnt_d         = '0;
            stall_cnt_d   = '0;
            timeout_err_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == XFER);
  end

  // State registers; reset points last_gnt at the top requester so requester 0 wins first.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      last_gnt_q    <= IW'(NUM_REQ - 1);
      stall_cnt_q   <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_gnt_q    <= last_gnt_d;
      stall_cnt_q   <= stall_cnt_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clock;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit pace = 0;
  bit r1_watch = 0;
  bit r1_bad = 0;
  int tout_cnt = 0;
  int tout_cyc = 0;

  logic [7:0] src_d [4][$];
  bit         src_l [4][$];
  int         sb_r [$];
  logic [7:0] sb_d [$];
  int         xcyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int r);
    return (r >= 0 && r < 4) ? 4'(1 << r) : 4'b0000;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_d[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = src_d[i][0];
        req_last[i]         = src_l[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
    tx_data_ready = pace ? ((cyc % 12) == 0) : 1'b1;
  endtask

  task automatic load(input int r, input int n, input logic [7:0] base, input bit last_on_end);
    for (int k = 0; k < n; k++) begin
      src_d[r].push_back(base + 8'(k));
      src_l[r].push_back(last_on_end && (k == n - 1));
      sb_r.push_back(r);
      sb_d.push_back(base + 8'(k));
    end
    drive();
  endtask

  task automatic tick();
    logic [3:0] fire;
    int         er;
    logic [7:0] ed;
    @(negedge clock);
    fire = req_valid & req_ready;
    if (r1_watch && src_d[2].size() > 0 && req_ready[1]) r1_bad = 1'b1;
    if (timeout_err) begin
      tout_cnt++;
      tout_cyc = cyc;
    end
    if (tx_data_valid && tx_data_ready) begin
      er = -1;
      ed = 8'h00;
      if (sb_r.size() > 0) begin
        er = sb_r.pop_front();
        ed = sb_d.pop_front();
      end
      xcyc.push_back(cyc);
      chk("sb_grant", {28'h0, grant}, {28'h0, oh(er)});
      chk("sb_data", {24'h0, tx_data}, {24'h0, ed});
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (fire[i] && src_d[i].size() > 0) begin
        void'(src_d[i].pop_front());
        void'(src_l[i].pop_front());
      end
    end
    drive();
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n;
    n = 0;
    while ((sb_r.size() > 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, sb_r.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int c0;
    int n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_data_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // reset state
    chk("rst_grant", {28'h0, grant}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_txv", {31'h0, tx_data_valid}, 32'h0);
    chk("rst_ready", {28'h0, req_ready}, 32'h0);
    chk("rst_txdata", {24'h0, tx_data}, 32'h0);
    chk("rst_tout", {31'h0, timeout_err}, 32'h0);

    // req0 three-byte packet
    xcyc.delete();
    load(0, 3, 8'h41, 1'b1);
    c0 = cyc;
    tick();
    chk("t1_grant", {28'h0, grant}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_txdata", {24'h0, tx_data}, 32'h41);
    wait_drain("t1_drain", 20);
    chk("t1_first_cyc", xcyc[0], c0 + 1);
    chk("t1_consec", xcyc[2] - xcyc[0], 2);
    chk("t1_idle_grant", {28'h0, grant}, 32'h0);
    chk("t1_idle_busy", {31'h0, busy}, 32'h0);

    // four requesters, two-byte packets, from a fresh reset
    do_reset();
    xcyc.delete();
    for (int r = 0; r < 4; r++) load(r, 2, 8'(8'h10 * (r + 1)), 1'b1);
    wait_drain("t2_drain", 60);
    chk("t2_count", xcyc.size(), 8);
    for (int k = 1; k < 8; k++) chk("t2_gap", xcyc[k] - xcyc[k-1], (k % 2 == 1) ? 1 : 2);

    // req2 owns a slow-paced transmitter while req1 waits
    pace = 1'b1;
    tout_cnt = 0;
    load(2, 3, 8'hC0, 1'b1);
    tick();
    chk("t3_grant2", {28'h0, grant}, 32'h4);
    r1_watch = 1'b1;
    load(1, 2, 8'hD0, 1'b1);
    wait_drain("t3_drain", 300);
    r1_watch = 1'b0;
    chk("t3_r1_no_ready", {31'h0, r1_bad}, 32'h0);
    chk("t3_no_tout", tout_cnt, 0);
    pace = 1'b0;
    drive();

    // req1 sends one byte without last and goes quiet
    xcyc.delete();
    tout_cnt = 0;
    load(1, 1, 8'h5A, 1'b0);
    n = 0;
    while (xcyc.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("t4_xfer_seen", xcyc.size(), 1);
    load(2, 1, 8'h77, 1'b1);
    n = 0;
    while (tout_cnt == 0 && n < 60) begin
      tick();
      n++;
    end
    chk("t4_tout_count", tout_cnt, 1);
    chk("t4_tout_delay", tout_cyc - xcyc[0], 17);
    chk("t4_next_grant", {28'h0, grant}, 32'h4);
    chk("t4_pulse_width", {31'h0, timeout_err}, 32'h0);
    wait_drain("t4_drain", 20);
    chk("t4_tout_once", tout_cnt, 1);

    // reset in the middle of a req3 packet
    xcyc.delete();
    load(3, 4, 8'hE0, 1'b1);
    n = 0;
    while (xcyc.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_started", {28'h0, grant}, 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_grant0", {28'h0, grant}, 32'h0);
    chk("t5_busy0", {31'h0, busy}, 32'h0);
    chk("t5_txv0", {31'h0, tx_data_valid}, 32'h0);
    chk("t5_ready0", {28'h0, req_ready}, 32'h0);
    chk("t5_txdata0", {24'h0, tx_data}, 32'h0);
    sb_r.delete();
    sb_d.delete();
    for (int i = 0; i < 4; i++) begin
      src_d[i].delete();
      src_l[i].delete();
    end
    load(0, 1, 8'h01, 1'b1);
    load(3, 2, 8'hE8, 1'b1);
    tick();
    chk("t5_held_ready", {28'h0, req_ready}, 32'h0);
    chk("t5_held_txv", {31'h0, tx_data_valid}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("t5_first_grant", {28'h0, grant}, 32'h1);
    wait_drain("t5_drain", 30);

    // req1 and req0 each hold eight single-byte packets: strict alternation
    xcyc.delete();
    for (int p = 0; p < 8; p++) begin
      load(0, 1, 8'(8'h80 + p), 1'b1);
      load(1, 1, 8'(8'h90 + p), 1'b1);
    end
    wait_drain("t6_drain", 120);
    chk("t6_count", xcyc.size(), 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
